// File: rtl/pc_gen_if.sv
// pc_gen_if: the front-end request/response bundle around the fetch PC
// generator.
//   Requests from the pipeline into the generator:
//     stall_if              hold the current fetch PC
//     redirect_valid/_pc    mispredict correction from EX
//     trap_valid/trap_vec   trap entry request and handler address
//     upd_valid/_pc/_target/_taken   BTB training from EX
//   Responses from the generator:
//     pc                    registered fetch PC
//     pred_taken            combinational BTB hit for pc
//     pred_target           BTB target for pc (0 on a miss)
//     misalign              one-cycle flag: last redirect target was misaligned
// Modports: master drives the requests (pipeline or bench), slave is pc_gen.
interface pc_gen_if #(
  parameter int unsigned XLEN = 32
) ();

  logic            stall_if;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            trap_valid;
  logic [XLEN-1:0] trap_vec;
  logic            upd_valid;
  logic [XLEN-1:0] upd_pc;
  logic [XLEN-1:0] upd_target;
  logic            upd_taken;

  logic [XLEN-1:0] pc;
  logic            pred_taken;
  logic [XLEN-1:0] pred_target;
  logic            misalign;

  modport master (
    output stall_if, redirect_valid, redirect_pc, trap_valid, trap_vec,
           upd_valid, upd_pc, upd_target, upd_taken,
    input  pc, pred_taken, pred_target, misalign
  );

  modport slave (
    input  stall_if, redirect_valid, redirect_pc, trap_valid, trap_vec,
           upd_valid, upd_pc, upd_target, upd_taken,
    output pc, pred_taken, pred_target, misalign
  );

endinterface

// File: rtl/pc_gen.sv
// pc_gen: fetch program-counter generator with a direct-mapped BTB.
//   clk   rising-edge clock for all state
//   rst   asynchronous active-low reset: pc=RESET_PC, misalign=0, BTB empty
//   bus   pc_gen_if slave port (requests in, pc/prediction/misalign out)
// Next-PC priority: trap > redirect > stall > BTB prediction > pc + IALIGN.
// The BTB is indexed by pc[L+I-1:L] and tagged with pc[XLEN-1:L+I], where
// L = log2(IALIGN) and I = log2(BTB_ENTRIES). Training writes land at the
// clock edge, so a lookup in the same cycle still sees the old entry.
module pc_gen #(
  parameter int unsigned     XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_PC    = '0,
  parameter int unsigned     IALIGN      = 4,
  parameter int unsigned     BTB_ENTRIES = 8
) (
  input  logic     clk,
  input  logic     rst,
  pc_gen_if.slave  bus
);

  localparam int unsigned     L          = $clog2(IALIGN);
  localparam int unsigned     I          = $clog2(BTB_ENTRIES);
  localparam int unsigned     TAG_W      = XLEN - L - I;
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(IALIGN - 1);
  localparam logic [XLEN-1:0] PC_STEP    = XLEN'(IALIGN);

  logic [XLEN-1:0]        pc_q, pc_d;
  logic                   misalign_q, misalign_d;
  logic [BTB_ENTRIES-1:0] btb_valid_q, btb_valid_d;
  logic [TAG_W-1:0]       btb_tag_q    [BTB_ENTRIES];
  logic [XLEN-1:0]        btb_target_q [BTB_ENTRIES];

  logic [I-1:0]     rd_idx, upd_idx;
  logic [TAG_W-1:0] rd_tag, upd_tag;
  logic             hit;
  logic [XLEN-1:0]  hit_target;
  logic             upd_write;

  // The sub-alignment bits of a branch PC never select a BTB entry.
  logic unused_upd_low;
  assign unused_upd_low = ^bus.upd_pc[L-1:0];

  // ---------------------------------------------------------------- lookup
  assign rd_idx     = pc_q[L+I-1:L];
  assign rd_tag     = pc_q[XLEN-1:L+I];
  assign hit        = btb_valid_q[rd_idx] && (btb_tag_q[rd_idx] == rd_tag);
  assign hit_target = hit ? (btb_target_q[rd_idx] & ALIGN_MASK) : '0;

  assign upd_idx    = bus.upd_pc[L+I-1:L];
  assign upd_tag    = bus.upd_pc[XLEN-1:L+I];
  assign upd_write  = bus.upd_valid && bus.upd_taken;

  assign bus.pc          = pc_q;
  assign bus.pred_taken  = hit;
  assign bus.pred_target = hit_target;
  assign bus.misalign    = misalign_q;

  // --------------------------------------------------------------- next PC
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    pc_d       = pc_q + PC_STEP;
    misalign_d = 1'b0;

    // Flushes from later stages beat the front-end hold.
    if (bus.trap_valid) begin
      pc_d = bus.trap_vec & ALIGN_MASK;
    end else if (bus.redirect_valid) begin
      pc_d       = bus.redirect_pc & ALIGN_MASK;
      misalign_d = (bus.redirect_pc[L-1:0] != '0);
    end else if (bus.stall_if) begin
      pc_d = pc_q;
    end else if (hit) begin
      pc_d = hit_target;
    end
  end

  // ------------------------------------------------------------ BTB valids
  always_comb begin
    btb_valid_d = btb_valid_q;
    if (bus.upd_valid) begin
      if (bus.upd_taken) begin
        btb_valid_d[upd_idx] = 1'b1;
      end else if (btb_tag_q[upd_idx] == upd_tag) begin
        // A not-taken outcome only evicts the branch it belongs to.
        btb_valid_d[upd_idx] = 1'b0;
      end
    end
  end

  // ------------------------------------------------------------------ state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q        <= RESET_PC;
      misalign_q  <= 1'b0;
      btb_valid_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      pc_q        <= pc_d;
      misalign_q  <= misalign_d;
      btb_valid_q <= btb_valid_d;
    end
  end

  // NOTE: tag/target storage is deliberately not reset; the valid bits
  // gate every use, so clearing the array would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (upd_write) begin
      btb_tag_q[upd_idx]    <= upd_tag;
      btb_target_q[upd_idx] <= bus.upd_target;
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: scoreboard bench for pc_gen.
// The driver applies one stimulus record per cycle at the falling edge,
// pushes the outputs the reference model says the DUT must be showing in
// that cycle, then advances the model across the coming rising edge.
// The monitor pops one expectation per cycle and compares it to the DUT.
// The model treats the BTB as plain arithmetic on addresses:
// index = (addr / IALIGN) % ENTRIES, tag = addr / (IALIGN * ENTRIES).
module tb_pc_gen;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned IALIGN   = 4;
  localparam int unsigned ENTRIES  = 8;
  localparam bit [31:0]   RESET_PC = 32'h0000_0000;

  typedef struct {
    bit        rst_n;
    bit        stall;
    bit        redir;
    bit [31:0] redir_pc;
    bit        trap;
    bit [31:0] trap_vec;
    bit        upd;
    bit        upd_taken;
    bit [31:0] upd_pc;
    bit [31:0] upd_tgt;
  } stim_t;

  typedef struct {
    bit [31:0] pc;
    bit        pred_taken;
    bit [31:0] pred_target;
    bit        misalign;
  } exp_t;

  logic clk;
  logic rst;
  pc_gen_if #(.XLEN(XLEN)) bus ();

  pc_gen #(
    .XLEN       (XLEN),
    .RESET_PC   (RESET_PC),
    .IALIGN     (IALIGN),
    .BTB_ENTRIES(ENTRIES)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int   n_vec = 0;
  int   n_err = 0;
  exp_t exp_q[$];

  // ---------------------------------------------------------- reference model
  bit [31:0] m_pc;
  bit        m_misalign;
  bit        m_valid [ENTRIES];
  bit [31:0] m_tag   [ENTRIES];
  bit [31:0] m_tgt   [ENTRIES];

  function automatic int unsigned idx_of(bit [31:0] a);
    return (a / IALIGN) % ENTRIES;
  endfunction

  function automatic bit [31:0] tag_of(bit [31:0] a);
    return a / (IALIGN * ENTRIES);
  endfunction

  function automatic bit [31:0] align(bit [31:0] a);
    return a - (a % IALIGN);
  endfunction

  function automatic bit m_hit();
    return m_valid[idx_of(m_pc)] && (m_tag[idx_of(m_pc)] == tag_of(m_pc));
  endfunction

  task automatic model_reset();
    m_pc       = RESET_PC;
    m_misalign = 1'b0;
    for (int i = 0; i < ENTRIES; i++) m_valid[i] = 1'b0;
  endtask

  function automatic exp_t model_outputs();
    exp_t e;
    e.pc          = m_pc;
    e.pred_taken  = m_hit();
    e.pred_target = m_hit() ? align(m_tgt[idx_of(m_pc)]) : 32'h0;
    e.misalign    = m_misalign;
    return e;
  endfunction

  task automatic model_advance(input stim_t s);
    bit [31:0]   nxt;
    int unsigned ui;
    if (s.trap)       nxt = align(s.trap_vec);
    else if (s.redir) nxt = align(s.redir_pc);
    else if (s.stall) nxt = m_pc;
    else if (m_hit()) nxt = align(m_tgt[idx_of(m_pc)]);
    else              nxt = m_pc + IALIGN;
    m_misalign = !s.trap && s.redir && (s.redir_pc % IALIGN != 0);
    m_pc = nxt;
    if (s.upd) begin
      ui = idx_of(s.upd_pc);
      if (s.upd_taken) begin
        m_valid[ui] = 1'b1;
        m_tag[ui]   = tag_of(s.upd_pc);
        m_tgt[ui]   = s.upd_tgt;
      end else if (m_tag[ui] == tag_of(s.upd_pc)) begin
        m_valid[ui] = 1'b0;
      end
    end
  endtask

  // ------------------------------------------------------------------ driver
  function automatic stim_t idle();
    stim_t s;
    s.rst_n = 1'b1; s.stall = 1'b0; s.redir = 1'b0; s.redir_pc = '0;
    s.trap = 1'b0; s.trap_vec = '0; s.upd = 1'b0; s.upd_taken = 1'b0;
    s.upd_pc = '0; s.upd_tgt = '0;
    return s;
  endfunction

  task automatic cycle(input stim_t s);
    @(negedge clk);
    rst                = s.rst_n;
    bus.stall_if       = s.stall;
    bus.redirect_valid = s.redir;
    bus.redirect_pc    = s.redir_pc;
    bus.trap_valid     = s.trap;
    bus.trap_vec       = s.trap_vec;
    bus.upd_valid      = s.upd;
    bus.upd_taken      = s.upd_taken;
    bus.upd_pc         = s.upd_pc;
    bus.upd_target     = s.upd_tgt;
    if (!s.rst_n) model_reset();
    exp_q.push_back(model_outputs());
    if (s.rst_n) model_advance(s);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cycle(idle());
  endtask

  task automatic reset_cycles(input int n);
    stim_t s;
    s = idle();
    s.rst_n = 1'b0;
    for (int i = 0; i < n; i++) cycle(s);
  endtask

  function automatic bit [31:0] rand_addr();
    if ($urandom_range(0, 4) == 0) return $urandom;
    return 32'($urandom_range(0, 255));
  endfunction

  // ----------------------------------------------------------------- monitor
  task automatic check(input string name, input bit [31:0] act, input bit [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("pc",          bus.pc,                  e.pc);
        check("pred_taken",  32'(bus.pred_taken),     32'(e.pred_taken));
        check("pred_target", bus.pred_target,         e.pred_target);
        check("misalign",    32'(bus.misalign),       32'(e.misalign));
      end
    end
  end

  // --------------------------------------------------------------- stimulus
  initial begin
    stim_t s;
    rst = 1'b0;
    bus.stall_if = 1'b0; bus.redirect_valid = 1'b0; bus.redirect_pc = '0;
    bus.trap_valid = 1'b0; bus.trap_vec = '0; bus.upd_valid = 1'b0;
    bus.upd_taken = 1'b0; bus.upd_pc = '0; bus.upd_target = '0;
    model_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_tag[i] = 32'hFFFF_FFFF;
      m_tgt[i] = '0;
    end

    // Reset release with no stimulus: 0x0, 0x4, 0x8, 0xC, no predictions.
    reset_cycles(2);
    idle_cycles(5);

    // Train 0x10 -> 0x40 while at pc 0, then run through the taken branch.
    reset_cycles(1);
    s = idle(); s.upd = 1'b1; s.upd_taken = 1'b1; s.upd_pc = 32'h10; s.upd_tgt = 32'h40;
    cycle(s);
    idle_cycles(7);

    // Misaligned redirect under stall: next pc 0x100, misalign for one cycle.
    s = idle(); s.stall = 1'b1; s.redir = 1'b1; s.redir_pc = 32'h102;
    cycle(s);
    s = idle(); s.stall = 1'b1;
    cycle(s);
    idle_cycles(2);

    // Trap and redirect together: trap wins, misalign stays clear.
    s = idle(); s.trap = 1'b1; s.trap_vec = 32'h80; s.redir = 1'b1; s.redir_pc = 32'h203;
    cycle(s);
    idle_cycles(2);

    // Not-taken update of an aliasing branch leaves 0x10 alone; its own
    // not-taken update evicts it, and the same-cycle lookup still hits.
    s = idle(); s.upd = 1'b1; s.upd_taken = 1'b1; s.upd_pc = 32'h10; s.upd_tgt = 32'h40;
    cycle(s);
    s = idle(); s.upd = 1'b1; s.upd_taken = 1'b0; s.upd_pc = 32'h30;
    cycle(s);
    s = idle(); s.redir = 1'b1; s.redir_pc = 32'h10;
    cycle(s);
    s = idle(); s.stall = 1'b1; s.upd = 1'b1; s.upd_taken = 1'b0; s.upd_pc = 32'h10;
    cycle(s);
    s = idle(); s.stall = 1'b1;
    cycle(s);
    idle_cycles(2);

    // Wrap from the top aligned address to 0.
    s = idle(); s.redir = 1'b1; s.redir_pc = 32'hFFFF_FFFC;
    cycle(s);
    idle_cycles(3);

    // Re-train 0x10, then reset in the middle of a stall with a redirect
    // pending: pc returns to RESET_PC at once and the BTB is empty.
    s = idle(); s.upd = 1'b1; s.upd_taken = 1'b1; s.upd_pc = 32'h10; s.upd_tgt = 32'h40;
    cycle(s);
    s = idle(); s.stall = 1'b1;
    cycle(s);
    cycle(s);
    s = idle(); s.rst_n = 1'b0; s.stall = 1'b1; s.redir = 1'b1; s.redir_pc = 32'h300;
    cycle(s);
    idle_cycles(7);

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 800; n++) begin
      s = idle();
      s.rst_n     = ($urandom_range(0, 99) != 0);
      s.stall     = ($urandom_range(0, 99) < 20);
      s.redir     = ($urandom_range(0, 99) < 10);
      s.redir_pc  = rand_addr();
      s.trap      = ($urandom_range(0, 99) < 3);
      s.trap_vec  = rand_addr();
      s.upd       = ($urandom_range(0, 99) < 35);
      s.upd_taken = ($urandom_range(0, 99) < 70);
      s.upd_pc    = rand_addr();
      s.upd_tgt   = rand_addr();
      cycle(s);
    end
    idle_cycles(2);

    // Let the monitor drain the last expectation.
    @(negedge clk);
    #2;
    check("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 SHALL have parameter XLEN, default 32, width of all address ports.
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-003 SHALL have parameter IALIGN, default 4, instruction alignment in bytes; legal values 2 and 4.
REQ-004 SHALL have parameter BTB_ENTRIES, default 8, branch-target-buffer depth; power of two, at least 2.
REQ-005 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst  input  1  asynchronous active-low reset (asserted at 0).
REQ-007 SHALL have port stall_if  input  1  hold the current PC.
REQ-008 SHALL have port redirect_valid  input  1  branch/jump resolved as mispredicted in EX.
REQ-009 SHALL have port redirect_pc  input  XLEN  correct target for a redirect.
REQ-010 SHALL have port trap_valid  input  1  trap/exception entry request.
REQ-011 SHALL have port trap_vec  input  XLEN  trap handler address.
REQ-012 SHALL have port upd_valid  input  1  BTB update strobe from EX.
REQ-013 SHALL have port upd_pc, upd_target  input  XLEN each  branch PC and resolved target.
REQ-014 SHALL have port upd_taken  input  1  resolved branch outcome.
REQ-015 SHALL have port pc  output  XLEN  current fetch PC, registered.
REQ-016 SHALL have port pred_taken  output  1  BTB hit on current pc, combinational.
REQ-017 SHALL have port pred_target  output  XLEN  BTB target for current pc, 0 when no hit.
REQ-018 SHALL have port misalign  output  1  registered one-cycle flag: last redirect target was misaligned.

Function
REQ-019 SHALL define low bits L = log2(IALIGN), index bits I = log2(BTB_ENTRIES), index = pc[L+I-1:L], tag = pc[XLEN-1:L+I].
REQ-020 SHALL select next PC with strict priority: trap_valid > redirect_valid > stall_if > pred_taken > pc + IALIGN.
REQ-021 SHALL let trap_valid and redirect_valid override stall_if (later-stage flush wins over front-end hold).
REQ-022 SHALL load trap_vec and redirect_pc with bits [L-1:0] forced to zero.
REQ-023 SHALL set misalign to 1 on the cycle after a taken redirect (not pre-empted by trap) whose redirect_pc[L-1:0] is nonzero, else 0.
REQ-024 SHALL compute pc + IALIGN modulo 2^XLEN; wrap from max aligned address to 0 without any flag.
REQ-025 SHALL hold pc unchanged under stall_if with no trap/redirect; pred outputs stay consistent with the held pc.
REQ-026 SHALL implement BTB as BTB_ENTRIES direct-mapped entries {valid, tag, target}.
REQ-027 SHALL assert pred_taken iff the entry at index(pc) is valid and its tag equals tag(pc); pred_target = that entry's target with low L bits cleared.
REQ-028 SHALL, on upd_valid with upd_taken=1, write entry at index(upd_pc) with valid=1, tag(upd_pc), upd_target (replacing any prior occupant).
REQ-029 SHALL, on upd_valid with upd_taken=0, clear valid of entry at index(upd_pc) only if that entry's tag matches tag(upd_pc); otherwise leave it untouched.
REQ-030 SHALL make BTB writes visible from the next cycle; a same-cycle lookup of the written index sees the old contents.
REQ-031 SHALL perform BTB updates regardless of stall_if, redirect_valid or trap_valid.

Reset
REQ-032 SHALL, while rst=0, asynchronously force pc=RESET_PC, misalign=0, all BTB valid bits=0 (targets/tags need not reset).
REQ-033 SHALL, on rst deassertion, present RESET_PC for one full cycle and advance per REQ-020 from the next rising edge.
REQ-034 SHALL treat reset asserted mid-stall or mid-redirect identically to REQ-032; pending inputs discarded.

Verification
REQ-035 SHALL check: reset release, no stimulus, defaults -> pc = 0x0, 0x4, 0x8, 0xC on successive cycles; pred_taken=0.
REQ-036 SHALL check: upd_valid, upd_pc=0x10, upd_target=0x40, upd_taken=1, then run from 0 -> pc sequence 0x0,0x4,0x8,0xC,0x10,0x40,0x44; pred_taken=1 only while pc=0x10.
REQ-037 SHALL check: stall_if=1 with redirect_valid=1, redirect_pc=0x102, trap_valid=0 -> next pc=0x100, misalign=1 for exactly one cycle.
REQ-038 SHALL check: trap_valid=1 (trap_vec=0x80) and redirect_valid=1 (redirect_pc=0x200) same cycle -> next pc=0x80, misalign=0.
REQ-039 SHALL check: entry for 0x10 valid, update with upd_pc=0x30 (same index for BTB_ENTRIES=8), upd_taken=0 -> entry for 0x10 still hits; then upd_pc=0x10, upd_taken=0 -> no hit at 0x10 next cycle.
REQ-040 SHALL check: pc=0xFFFF_FFFC, no stall -> next pc=0x0; rst pulsed low mid-stall -> pc=RESET_PC immediately, all BTB lookups miss.
